stim_sequencer: RTL and testbench

STIM_SEQUENCER -- requirements
Module: stim_sequencer

---
 rtl/stim_sequencer.sv | 167 ++++++++++++++++
 tb/tb_stim_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stim_sequencer.sv
// LCG-driven stimulus sequencer: builds each IN_W-bit vector from NW generator words,
// applies it for one cycle and compresses the sampled response into a 32-bit MISR.
module stim_sequencer #(
    parameter int          IN_W         = 143,
    parameter int          OUT_W        = 159,
    parameter logic [31:0] DEFAULT_SEED = 32'd2048741382
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             seed_vld,
    input  logic [31:0]      seed,
    input  logic [31:0]      cycles,
    input  logic [OUT_W-1:0] out_flat,
    output logic [IN_W-1:0]  in_flat,
    output logic             vec_vld,
    output logic             busy,
    output logic             done,
    output logic [31:0]      vec_cnt,
    output logic [31:0]      signature
);

    localparam int NW     = (IN_W + 31) / 32;
    localparam int NWO    = (OUT_W + 31) / 32;
    localparam int LAST_W = IN_W - 32 * (NW - 1);
    localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NW - 1);
    localparam logic [31:0]      LAST_MASK = (LAST_W == 32) ? 32'hFFFF_FFFF
                                                            : ((32'd1 << LAST_W) - 32'd1);
    localparam logic [31:0]      LCG_MUL   = 32'h41C6_4E6D;
    localparam logic [31:0]      LCG_ADD   = 32'h0000_3039;
    localparam logic [31:0]      MISR_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_APPLY,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [31:0]         r_gen;
    logic [IDX_W-1:0]    r_idx;
    logic [31:0]         r_shadow [NW];
    logic [IN_W-1:0]     r_in_flat;
    logic                r_vec_vld;
    logic [31:0]         r_vec_cnt;
    logic [31:0]         r_sig;
    logic [31:0]         r_cycles;

    logic                w_accept;
    logic                w_seed_load;
    logic                w_last_fill;
    logic [31:0]         w_lcg;
    logic [31:0]         w_cnt_inc;
    logic [31:0]         w_fold;
    logic [31:0]         w_sig_next;
    logic [32*NW-1:0]    w_fill_flat;
    logic [32*NWO-1:0]   w_out_pad;

    assign w_lcg       = r_gen * LCG_MUL + LCG_ADD;
    assign w_cnt_inc   = r_vec_cnt + 32'd1;
    assign w_last_fill = (r_state == S_FILL) && (r_idx == LAST_IDX);
    assign w_out_pad   = (32*NWO)'(out_flat);

    // Shadow image with the word being generated this cycle merged in, so the
    // final FILL cycle can publish the complete vector in one step.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_fill
            localparam logic [31:0] WORD_MASK = (gi == NW - 1) ? LAST_MASK : 32'hFFFF_FFFF;
            assign w_fill_flat[32*gi +: 32] = (r_idx == IDX_W'(gi)) ? (w_lcg & WORD_MASK)
                                                                    : r_shadow[gi];
        end
    endgenerate

    always_comb begin
        w_fold = 32'h0;
        for (int i = 0; i < NWO; i++) begin
            w_fold = w_fold ^ w_out_pad[32*i +: 32];
        end
    end

    assign w_sig_next = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0) ^ w_fold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_seed_load  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_seed_load = seed_vld;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (cycles == 32'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                w_state_next = (w_cnt_inc == r_cycles) ? S_DONE : S_FILL;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen     <= DEFAULT_SEED;
            r_idx     <= '0;
            r_in_flat <= '0;
            r_vec_vld <= 1'b0;
            r_vec_cnt <= 32'h0;
            r_sig     <= 32'h0;
            r_cycles  <= 32'h0;
            for (int i = 0; i < NW; i++) begin
                r_shadow[i] <= 32'h0;
            end
        end else begin
            r_vec_vld <= 1'b0;
            if (w_seed_load) begin
                r_gen <= seed;
            end
            if (w_accept) begin
                r_cycles  <= cycles;
                r_vec_cnt <= 32'h0;
                r_sig     <= 32'hFFFF_FFFF;
                r_idx     <= '0;
            end
            if (r_state == S_FILL) begin
                r_gen <= w_lcg;
                r_idx <= w_last_fill ? '0 : r_idx + IDX_W'(1);
                for (int i = 0; i < NW; i++) begin
                    r_shadow[i] <= w_fill_flat[32*i +: 32];
                end
                if (w_last_fill) begin
                    r_in_flat <= w_fill_flat[IN_W-1:0];
                    r_vec_vld <= 1'b1;
                end
            end
            if (r_state == S_APPLY) begin
                r_sig     <= w_sig_next;
                r_vec_cnt <= w_cnt_inc;
            end
        end
    end

    assign in_flat   = r_in_flat;
    assign vec_vld   = r_vec_vld;
    assign busy      = (r_state == S_FILL) || (r_state == S_APPLY);
    assign done      = (r_state == S_DONE);
    assign vec_cnt   = r_vec_cnt;
    assign signature = r_sig;

endmodule

// File: tb/tb_stim_sequencer.sv
module tb_stim_sequencer;

    localparam int          IN_W     = 143;
    localparam int          OUT_W    = 159;
    localparam int          NW       = (IN_W + 31) / 32;
    localparam logic [31:0] DEF_SEED = 32'd2048741382;
    localparam logic [OUT_W-1:0] PAT = 159'h5A5A_1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_C0D;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             seed_vld;
    logic [31:0]      seed;
    logic [31:0]      cycles;
    logic [OUT_W-1:0] out_flat;
    logic [IN_W-1:0]  in_flat;
    logic             vec_vld;
    logic             busy;
    logic             done;
    logic [31:0]      vec_cnt;
    logic [31:0]      signature;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]     m_gen;
    logic [31:0]     m_sig;
    logic [IN_W-1:0] last_exp;
    logic [IN_W-1:0] ref_vec;
    logic [IN_W-1:0] exp_vecs [$];
    logic [IN_W-1:0] obs_vecs [$];

    stim_sequencer #(
        .IN_W         (IN_W),
        .OUT_W        (OUT_W),
        .DEFAULT_SEED (DEF_SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed_vld  (seed_vld),
        .seed      (seed),
        .cycles    (cycles),
        .out_flat  (out_flat),
        .in_flat   (in_flat),
        .vec_vld   (vec_vld),
        .busy      (busy),
        .done      (done),
        .vec_cnt   (vec_cnt),
        .signature (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lcg(input logic [31:0] s);
        return s * 32'h41C6_4E6D + 32'h0000_3039;
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [OUT_W-1:0] r);
        logic [31:0] f;
        f = 32'h0;
        for (int i = 0; i < OUT_W; i++) begin
            f[i % 32] = f[i % 32] ^ r[i];
        end
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
    endfunction

    task automatic model_vec(output logic [IN_W-1:0] v);
        logic [32*NW-1:0] tmp;
        tmp = '0;
        for (int w = 0; w < NW; w++) begin
            m_gen = lcg(m_gen);
            tmp[32*w +: 32] = m_gen;
        end
        v = tmp[IN_W-1:0];
    endtask

    task automatic do_run(input int n, input bit do_seed, input logic [31:0] s,
                          input bit disturb, input logic [OUT_W-1:0] resp);
        logic [IN_W-1:0] ev;
        int t, pulses, last_pulse, t_done;
        bit fin;
        out_flat = resp;
        start    = 1'b1;
        cycles   = n;
        if (do_seed) begin
            seed_vld = 1'b1;
            seed     = s;
            m_gen    = s;
        end
        @(negedge clk);
        start    = 1'b0;
        seed_vld = 1'b0;
        cycles   = 32'h0000_0055;
        m_sig    = 32'hFFFF_FFFF;
        exp_vecs.delete();
        obs_vecs.delete();
        pulses     = 0;
        last_pulse = -1;
        t_done     = -1;
        fin        = 1'b0;
        t          = 0;
        if (n > 0) begin
            check("busy_at_start", busy, 1'b1);
        end
        while (!fin && t <= n * (NW + 1) + 20) begin
            if (vec_vld) begin
                model_vec(ev);
                exp_vecs.push_back(ev);
                obs_vecs.push_back(in_flat);
                last_exp = ev;
                m_sig    = misr(m_sig, resp);
                check("in_flat", in_flat, ev);
                if (pulses == 0) begin
                    check("first_vec_time", t, NW);
                end else begin
                    check("vec_period", t - last_pulse, NW + 1);
                end
                last_pulse = t;
                pulses++;
            end
            if (done) begin
                fin    = 1'b1;
                t_done = t;
            end else begin
                if (disturb && t == 1) begin
                    start    = 1'b1;
                    seed_vld = 1'b1;
                    seed     = 32'hDEAD_BEEF;
                    cycles   = 32'd7;
                end
                if (disturb && t == 2) begin
                    start    = 1'b0;
                    seed_vld = 1'b0;
                    cycles   = 32'h0000_0055;
                end
                @(negedge clk);
                t++;
            end
        end
        check("done_reached", fin, 1'b1);
        check("run_length", t_done, n * (NW + 1));
        check("vec_vld_count", pulses, n);
        check("vec_cnt", vec_cnt, n);
        check("signature", signature, m_sig);
        check("busy_in_done", busy, 1'b0);
        if (n == 0) begin
            check("in_flat_held", in_flat, last_exp);
        end
        $display("run cycles=%0d seed_load=%0d disturb=%0d: vectors=%0d vec_cnt=%0d signature=%08h",
                 n, do_seed, disturb, pulses, vec_cnt, signature);
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        seed_vld = 1'b0;
        seed     = 32'h0;
        cycles   = 32'h0;
        out_flat = '0;
        m_gen    = DEF_SEED;
        m_sig    = 32'h0;
        last_exp = '0;
        ref_vec  = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_flat", in_flat, {IN_W{1'b0}});
        check("rst_vec_vld", vec_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_vec_cnt", vec_cnt, 32'h0);
        check("rst_signature", signature, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);

        seed_vld = 1'b1;
        seed     = 32'h0;
        @(negedge clk);
        seed_vld = 1'b0;
        m_gen    = 32'h0;
        do_run(1, 1'b0, 32'h0, 1'b0, '0);
        check("seed0_word0", in_flat[31:0], 32'h0000_3039);
        check("seed0_word1", in_flat[63:32], 32'hD3DC_167E);
        check("seed0_sig", signature, 32'hFB3E_E249);

        do_run(0, 1'b0, 32'h0, 1'b0, '0);
        check("zero_run_sig", signature, 32'hFFFF_FFFF);

        do_run(3, 1'b0, 32'h0, 1'b0, '0);
        check("zero_resp_sig", signature, 32'hE1B8_AFFD);

        do_run(2, 1'b0, 32'h0, 1'b1, PAT);

        do_run(2, 1'b1, 32'h1234_5678, 1'b0, PAT);
        do_run(2, 1'b0, 32'h0, 1'b0, PAT);
        ref_vec = exp_vecs[0];
        do_run(4, 1'b1, 32'h1234_5678, 1'b0, PAT);
        check("back_to_back_vec", obs_vecs[2], ref_vec);

        start  = 1'b1;
        cycles = 32'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_flat", in_flat, {IN_W{1'b0}});
        check("abort_vec_vld", vec_vld, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_vec_cnt", vec_cnt, 32'h0);
        check("abort_signature", signature, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_gen = DEF_SEED;
        @(negedge clk);
        check("post_abort_idle", busy, 1'b0);
        check("post_abort_done", done, 1'b0);
        do_run(1, 1'b0, 32'h0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
